// File: rtl/twos_comp_sign_mag_serializer_if.sv
// Handshake bundle between the two's-complement source, the serializer and the serial sink.
interface twos_comp_sign_mag_serializer_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_last;
  logic             sign_out;
  logic [WIDTH-1:0] mag_out;
  logic             done;

  modport master (
    output in_data, in_valid, ser_ready,
    input  in_ready, ser_out, ser_valid, ser_last, sign_out, mag_out, done
  );

  modport slave (
    input  in_data, in_valid, ser_ready,
    output in_ready, ser_out, ser_valid, ser_last, sign_out, mag_out, done
  );
endinterface

// File: rtl/twos_comp_sign_mag_serializer.sv
// Converts a two's-complement word to sign-magnitude and streams it out as
// a sign-first, magnitude-LSB-first frame with ready/valid backpressure.
module twos_comp_sign_mag_serializer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  twos_comp_sign_mag_serializer_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic [WIDTH-1:0] sreg, sreg_next;
  logic             ser_out_next, ser_valid_next, ser_last_next;
  logic             sign_next, done_next, in_ready_next;
  logic [WIDTH-1:0] mag_next;

  logic             accept_c, hs_c, in_sign_c;
  logic [WIDTH-1:0] in_mag_c;

  assign accept_c  = bus.in_valid & bus.in_ready & (state == IDLE);
  assign hs_c      = bus.ser_valid & bus.ser_ready & (state == SHIFT);
  assign in_sign_c = bus.in_data[WIDTH-1];
  // Most-negative input wraps to itself, which reads correctly as an unsigned magnitude.
  assign in_mag_c  = in_sign_c ? WIDTH'(~bus.in_data + WIDTH'(1)) : bus.in_data;

  // State and all output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      sreg          <= '0;
      bus.ser_out   <= 1'b0;
      bus.ser_valid <= 1'b0;
      bus.ser_last  <= 1'b0;
      bus.sign_out  <= 1'b0;
      bus.mag_out   <= '0;
      bus.done      <= 1'b0;
      bus.in_ready  <= 1'b0;
    end else begin
      state         <= state_next;
      idx           <= idx_next;
      sreg          <= sreg_next;
      bus.ser_out   <= ser_out_next;
      bus.ser_valid <= ser_valid_next;
      bus.ser_last  <= ser_last_next;
      bus.sign_out  <= sign_next;
      bus.mag_out   <= mag_next;
      bus.done      <= done_next;
      bus.in_ready  <= in_ready_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_c) state_next = SHIFT;
      SHIFT:   if (hs_c && (idx == LAST_IDX)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of datapath and registered outputs
  always_comb begin
    idx_next       = idx;
    sreg_next      = sreg;
    ser_out_next   = bus.ser_out;
    ser_valid_next = bus.ser_valid;
    ser_last_next  = bus.ser_last;
    sign_next      = bus.sign_out;
    mag_next       = bus.mag_out;
    done_next      = 1'b0;
    in_ready_next  = (state_next == IDLE);

    case (state)
      IDLE: begin
        if (accept_c) begin
          sign_next      = in_sign_c;
          mag_next       = in_mag_c;
          sreg_next      = in_mag_c;
          ser_out_next   = in_sign_c;
          ser_valid_next = 1'b1;
          ser_last_next  = 1'b0;
          idx_next       = '0;
        end
      end
      SHIFT: begin
        if (hs_c) begin
          if (idx == LAST_IDX) begin
            ser_out_next   = 1'b0;
            ser_valid_next = 1'b0;
            ser_last_next  = 1'b0;
            done_next      = 1'b1;
            idx_next       = '0;
            sreg_next      = '0;
          end else begin
            ser_out_next  = sreg[0];
            sreg_next     = sreg >> 1;
            idx_next      = idx + IDX_W'(1);
            ser_last_next = ((idx + IDX_W'(1)) == LAST_IDX);
          end
        end
      end
      DONE: begin
        ser_valid_next = 1'b0;
      end
      default: begin
        ser_valid_next = 1'b0;
      end
    endcase
  end
endmodule
